// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: launches the md unit from E, counts its fixed latency,
// commits the result into HI/LO and stalls D-stage HI/LO users meanwhile.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md_use,
    output logic        md_start,
    output logic        md_is_div,
    output logic        md_signed,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        dbg_state,
    output logic [3:0]  dbg_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        md_start_q, md_start_d;
    logic        md_is_div_q, md_is_div_d;
    logic        md_signed_q, md_signed_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic is_mul;
    logic is_div;
    logic idle;
    logic accept;
    logic mthi_wr;
    logic mtlo_wr;

    // Divide by zero is never launched; it completes as a no-op in the accept cycle.
    always_comb begin
        is_mul  = (e_op == 3'd1) || (e_op == 3'd2);
        is_div  = (e_op == 3'd3) || (e_op == 3'd4);
        idle    = (state_q == ST_IDLE);
        accept  = e_valid && idle && (is_mul || (is_div && (e_rt != 32'd0)));
        mthi_wr = e_valid && idle && (e_op == 3'd5);
        mtlo_wr = e_valid && idle && (e_op == 3'd6);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_start_d  = 1'b0;
        md_is_div_d = md_is_div_q;
        md_signed_d = md_signed_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_RUN;
                    md_start_d  = 1'b1;
                    md_is_div_d = is_div;
                    md_signed_d = (e_op == 3'd1) || (e_op == 3'd3);
                    md_a_d      = e_rs;
                    md_b_d      = e_rt;
                    cnt_d       = is_div ? DIV_LOAD : MULT_LOAD;
                end else if (mthi_wr) begin
                    hi_d = e_rs;
                end else if (mtlo_wr) begin
                    lo_d = e_rs;
                end
            end
            ST_RUN: begin
                // E-stage ops arriving here are protocol violations and are dropped.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hi_d    = md_hi;
                    lo_d    = md_lo;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            md_start_q  <= 1'b0;
            md_is_div_q <= 1'b0;
            md_signed_q <= 1'b0;
            md_a_q      <= 32'd0;
            md_b_q      <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_start_q  <= md_start_d;
            md_is_div_q <= md_is_div_d;
            md_signed_q <= md_signed_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    always_comb begin
        md_start  = md_start_q;
        md_is_div = md_is_div_q;
        md_signed = md_signed_q;
        md_a      = md_a_q;
        md_b      = md_b_q;
        busy      = (state_q == ST_RUN);
        hi        = hi_q;
        lo        = lo_q;
        stall     = d_md_use && ((state_q == ST_RUN) || accept);
        dbg_state = state_q;
        dbg_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: each scenario task drives E-stage ops, plays the
// md unit by presenting hand-computed results, and checks outputs inline.
module tb_md_sequencer;

    logic        clk;
    logic        rst_n;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic        md_start;
    logic        md_is_div;
    logic        md_signed;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        dbg_state;
    logic [3:0]  dbg_cnt;

    int pass_cnt;
    int total_cnt;

    localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
        .d_md_use(d_md_use), .md_start(md_start), .md_is_div(md_is_div), .md_signed(md_signed),
        .md_a(md_a), .md_b(md_b), .md_hi(md_hi), .md_lo(md_lo), .busy(busy), .hi(hi), .lo(lo),
        .stall(stall), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        e_valid = 1'b1;
        e_op    = op;
        e_rs    = rs;
        e_rt    = rt;
    endtask

    task automatic idle_e();
        e_valid = 1'b0;
        e_op    = OP_NONE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_e(); e_rs = '0; e_rt = '0; d_md_use = 1'b0; md_hi = '0; md_lo = '0;
        #12 rst_n = 1'b1;
        step();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (md_start !== 1'b0) $display("FAIL reset_start: got %0b want 0", md_start); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); else pass_cnt++;
        total_cnt++; if (md_a !== 32'd0 || md_b !== 32'd0) $display("FAIL reset_ops: got %h/%h want 0/0", md_a, md_b); else pass_cnt++;
    endtask

    task automatic test_mult();
        int bcount;
        md_hi = 32'd0; md_lo = 32'd21; d_md_use = 1'b1;
        issue(OP_MULT, 32'd3, 32'd7);
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL mult_accept_stall: got %0b want 1", stall); else pass_cnt++;
        step();
        idle_e(); d_md_use = 1'b0;
        total_cnt++; if (md_a !== 32'd3 || md_b !== 32'd7) $display("FAIL mult_ops: got %0d/%0d want 3/7", md_a, md_b); else pass_cnt++;
        total_cnt++; if (md_signed !== 1'b1 || md_is_div !== 1'b0) $display("FAIL mult_kind: got s=%0b d=%0b want s=1 d=0", md_signed, md_is_div); else pass_cnt++;
        total_cnt++; if (dbg_cnt !== 4'd4) $display("FAIL mult_cnt_load: got %0d want 4", dbg_cnt); else pass_cnt++;
        bcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            total_cnt++; if (md_start !== (i == 0)) $display("FAIL mult_start_pulse: cycle %0d got %0b want %0b", i, md_start, (i == 0)); else pass_cnt++;
            total_cnt++; if (lo !== 32'd0) $display("FAIL mult_early_commit: cycle %0d lo got %0d want 0", i, lo); else pass_cnt++;
            bcount++;
            step();
        end
        total_cnt++; if (bcount !== 5) $display("FAIL mult_busy_len: got %0d want 5", bcount); else pass_cnt++;
        total_cnt++; if (lo !== 32'd21 || hi !== 32'd0) $display("FAIL mult_result: got hi=%0d lo=%0d want 0/21", hi, lo); else pass_cnt++;
    endtask

    task automatic test_divu();
        int bcount;
        md_hi = 32'd2; md_lo = 32'd14; d_md_use = 1'b1;
        issue(OP_DIVU, 32'd100, 32'd7);
        step();
        idle_e();
        total_cnt++; if (md_start !== 1'b1 || md_is_div !== 1'b1 || md_signed !== 1'b0) $display("FAIL divu_launch: got start=%0b div=%0b s=%0b want 1/1/0", md_start, md_is_div, md_signed); else pass_cnt++;
        bcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            total_cnt++; if (stall !== 1'b1) $display("FAIL divu_stall: cycle %0d got %0b want 1", i, stall); else pass_cnt++;
            bcount++;
            step();
        end
        total_cnt++; if (bcount !== 10) $display("FAIL divu_busy_len: got %0d want 10", bcount); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL divu_stall_drop: got %0b want 0", stall); else pass_cnt++;
        total_cnt++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_result: got hi=%0d lo=%0d want 2/14", hi, lo); else pass_cnt++;
        d_md_use = 1'b0;
    endtask

    task automatic test_div_zero();
        issue(OP_MTHI, 32'hDEAD, 32'd0);
        step();
        total_cnt++; if (hi !== 32'hDEAD || busy !== 1'b0) $display("FAIL mthi_write: got hi=%h busy=%0b want dead/0", hi, busy); else pass_cnt++;
        d_md_use = 1'b1;
        issue(OP_DIV, 32'd5, 32'd0);
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL divz_stall: got %0b want 0", stall); else pass_cnt++;
        step();
        idle_e();
        total_cnt++; if (md_start !== 1'b0 || busy !== 1'b0) $display("FAIL divz_launch: got start=%0b busy=%0b want 0/0", md_start, busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'hDEAD || lo !== 32'd14) $display("FAIL divz_hilo: got %h/%h want dead/e", hi, lo); else pass_cnt++;
        step();
        total_cnt++; if (busy !== 1'b0 || stall !== 1'b0) $display("FAIL divz_after: got busy=%0b stall=%0b want 0/0", busy, stall); else pass_cnt++;
        d_md_use = 1'b0;
    endtask

    task automatic test_mtlo();
        int bcount;
        issue(OP_MTLO, 32'h1234, 32'd0);
        step();
        idle_e();
        total_cnt++; if (lo !== 32'h1234 || busy !== 1'b0 || hi !== 32'hDEAD) $display("FAIL mtlo_write: got lo=%h hi=%h busy=%0b want 1234/dead/0", lo, hi, busy); else pass_cnt++;
        md_hi = 32'd0; md_lo = 32'd4;
        issue(OP_MULTU, 32'd2, 32'd2);
        step();
        idle_e();
        total_cnt++; if (md_signed !== 1'b0) $display("FAIL multu_signed: got %0b want 0", md_signed); else pass_cnt++;
        bcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            if (i == 1) issue(OP_MTLO, 32'hBEEF, 32'd0);
            else idle_e();
            total_cnt++; if (lo !== 32'h1234) $display("FAIL mtlo_ignored: cycle %0d lo got %h want 1234", i, lo); else pass_cnt++;
            bcount++;
            step();
        end
        idle_e();
        total_cnt++; if (bcount !== 5) $display("FAIL multu_busy_len: got %0d want 5", bcount); else pass_cnt++;
        total_cnt++; if (lo !== 32'd4 || hi !== 32'd0) $display("FAIL multu_result: got hi=%0d lo=%0d want 0/4", hi, lo); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bcount;
        md_hi = 32'd7; md_lo = 32'd81;
        issue(OP_MULT, 32'd9, 32'd9);
        step();
        idle_e();
        step(); step(); step();
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy: got %0b want 1", busy); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || md_start !== 1'b0) $display("FAIL rstmid_async: got busy=%0b start=%0b want 0/0", busy, md_start); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0 || md_a !== 32'd0) $display("FAIL rstmid_regs: got hi=%h lo=%h a=%h want 0", hi, lo, md_a); else pass_cnt++;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total_cnt++; if (busy !== 1'b0 || lo !== 32'd0 || hi !== 32'd0) $display("FAIL rstmid_no_commit: got busy=%0b hi=%0d lo=%0d want 0/0/0", busy, hi, lo); else pass_cnt++;
        md_hi = 32'd0; md_lo = 32'd15;
        issue(OP_MULT, 32'd3, 32'd5);
        step();
        idle_e();
        total_cnt++; if (md_start !== 1'b1 || busy !== 1'b1) $display("FAIL rstmid_relaunch: got start=%0b busy=%0b want 1/1", md_start, busy); else pass_cnt++;
        bcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            bcount++;
            step();
        end
        total_cnt++; if (bcount !== 5 || lo !== 32'd15) $display("FAIL rstmid_result: got len=%0d lo=%0d want 5/15", bcount, lo); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bcount;
        md_hi = 32'd0; md_lo = 32'd42; d_md_use = 1'b1;
        issue(OP_MULT, 32'd6, 32'd7);
        step();
        issue(OP_DIVU, 32'd50, 32'd8);
        bcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            total_cnt++; if (md_a !== 32'd6 || md_b !== 32'd7) $display("FAIL b2b_mult_ops: cycle %0d got %0d/%0d want 6/7", i, md_a, md_b); else pass_cnt++;
            total_cnt++; if (stall !== 1'b1) $display("FAIL b2b_mult_stall: cycle %0d got %0b want 1", i, stall); else pass_cnt++;
            bcount++;
            step();
        end
        total_cnt++; if (bcount !== 5 || lo !== 32'd42) $display("FAIL b2b_mult_result: got len=%0d lo=%0d want 5/42", bcount, lo); else pass_cnt++;
        total_cnt++; if (md_start !== 1'b0 || md_a !== 32'd6) $display("FAIL b2b_no_accept_at_commit: got start=%0b a=%0d want 0/6", md_start, md_a); else pass_cnt++;
        total_cnt++; if (stall !== 1'b1) $display("FAIL b2b_accept_stall: got %0b want 1", stall); else pass_cnt++;
        md_hi = 32'd2; md_lo = 32'd6;
        step();
        idle_e();
        total_cnt++; if (md_start !== 1'b1 || md_is_div !== 1'b1) $display("FAIL b2b_divu_launch: got start=%0b div=%0b want 1/1", md_start, md_is_div); else pass_cnt++;
        bcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            total_cnt++; if (md_a !== 32'd50 || md_b !== 32'd8) $display("FAIL b2b_divu_ops: cycle %0d got %0d/%0d want 50/8", i, md_a, md_b); else pass_cnt++;
            bcount++;
            step();
        end
        total_cnt++; if (bcount !== 10 || hi !== 32'd2 || lo !== 32'd6) $display("FAIL b2b_divu_result: got len=%0d hi=%0d lo=%0d want 10/2/6", bcount, hi, lo); else pass_cnt++;
        d_md_use = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_mult();
        test_divu();
        test_div_zero();
        test_mtlo();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
